// File: rtl/if_id_register.sv
// IF/ID pipeline register for a three-slot (I, J, R) fetch packet.
// It holds the packet for decode, stalls on a load-use dependency and
// squashes the packet on a redirect. After program end it goes quiet.
// It also keeps two saturating performance counters.
module if_id_register #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             btnc_i,
  input  logic [31:0]      program_counter,
  input  logic [31:0]      instruction_i,
  input  logic [31:0]      instruction_j,
  input  logic [31:0]      instruction_r,
  input  logic             type_i,
  input  logic             type_j,
  input  logic             type_r,
  input  logic             PCSrc,
  input  logic             jump,
  input  logic             finish,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  output logic [31:0]      pc_id,
  output logic [31:0]      inst_i_id,
  output logic [31:0]      inst_j_id,
  output logic [31:0]      inst_r_id,
  output logic             valid_i_id,
  output logic             valid_j_id,
  output logic             valid_r_id,
  output logic             hazard,
  output logic             halted,
  output logic [CNT_W-1:0] packet_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       issue_count
);

  // A load's rt field is its destination, not a source operand.
  localparam logic [5:0] OP_LW = 6'b100011;

  logic [31:0]      r_pc;
  logic [31:0]      r_inst_i;
  logic [31:0]      r_inst_j;
  logic [31:0]      r_inst_r;
  logic             r_valid_i;
  logic             r_valid_j;
  logic             r_valid_r;
  logic             r_halted;
  logic [CNT_W-1:0] r_packet_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_flush;
  logic             w_match_i;
  logic             w_match_r;
  logic             w_hazard;
  logic             w_pkt_inc;
  logic             w_bub_inc;
  logic [31:0]      w_pc_n;
  logic [31:0]      w_inst_i_n;
  logic [31:0]      w_inst_j_n;
  logic [31:0]      w_inst_r_n;
  logic             w_valid_i_n;
  logic             w_valid_j_n;
  logic             w_valid_r_n;
  logic [CNT_W-1:0] w_packet_cnt_n;
  logic [CNT_W-1:0] w_bubble_cnt_n;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             en);
    if (en && (cnt != {CNT_W{1'b1}})) begin
      f_sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      f_sat_inc = cnt;
    end
  endfunction

  assign w_flush = PCSrc | jump;

  // The J slot reads no registers, so it never takes part in a load-use match.
  assign w_match_r = r_valid_r &
                     ((r_inst_r[25:21] == id_ex_rt) | (r_inst_r[20:16] == id_ex_rt));
  assign w_match_i = r_valid_i &
                     ((r_inst_i[25:21] == id_ex_rt) |
                      ((r_inst_i[31:26] != OP_LW) & (r_inst_i[20:16] == id_ex_rt)));

  // A redirect or halt outranks a stall, so either one masks the hazard.
  assign w_hazard = id_ex_memread & (id_ex_rt != 5'd0) & ~w_flush & ~r_halted &
                    (w_match_i | w_match_r);

  assign w_pkt_inc = ~r_halted & ~w_flush & ~w_hazard & (type_i | type_j | type_r);
  assign w_bub_inc = ~r_halted & (w_flush | w_hazard);

  // Next packet state: halted > flush > hazard hold > normal load.
  always_comb begin
    w_pc_n      = r_pc;
    w_inst_i_n  = r_inst_i;
    w_inst_j_n  = r_inst_j;
    w_inst_r_n  = r_inst_r;
    w_valid_i_n = r_valid_i;
    w_valid_j_n = r_valid_j;
    w_valid_r_n = r_valid_r;
    if (r_halted) begin
      w_inst_i_n  = 32'd0;
      w_inst_j_n  = 32'd0;
      w_inst_r_n  = 32'd0;
      w_valid_i_n = 1'b0;
      w_valid_j_n = 1'b0;
      w_valid_r_n = 1'b0;
    end else if (w_flush) begin
      w_pc_n      = program_counter;
      w_inst_i_n  = 32'd0;
      w_inst_j_n  = 32'd0;
      w_inst_r_n  = 32'd0;
      w_valid_i_n = 1'b0;
      w_valid_j_n = 1'b0;
      w_valid_r_n = 1'b0;
    end else if (w_hazard) begin
      w_pc_n      = r_pc;
    end else begin
      w_pc_n      = program_counter;
      w_inst_i_n  = type_i ? instruction_i : 32'd0;
      w_inst_j_n  = type_j ? instruction_j : 32'd0;
      w_inst_r_n  = type_r ? instruction_r : 32'd0;
      w_valid_i_n = type_i;
      w_valid_j_n = type_j;
      w_valid_r_n = type_r;
    end
  end

  // Next counter values; the increment enables already exclude the halted state.
  always_comb begin
    w_packet_cnt_n = f_sat_inc(r_packet_cnt, w_pkt_inc);
    w_bubble_cnt_n = f_sat_inc(r_bubble_cnt, w_bub_inc);
  end

  // State register; reset wins over everything, including a stall or halt.
  always_ff @(posedge clk) begin
    if (btnc_i) begin
      r_pc         <= 32'd0;
      r_inst_i     <= 32'd0;
      r_inst_j     <= 32'd0;
      r_inst_r     <= 32'd0;
      r_valid_i    <= 1'b0;
      r_valid_j    <= 1'b0;
      r_valid_r    <= 1'b0;
      r_halted     <= 1'b0;
      r_packet_cnt <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      r_pc         <= w_pc_n;
      r_inst_i     <= w_inst_i_n;
      r_inst_j     <= w_inst_j_n;
      r_inst_r     <= w_inst_r_n;
      r_valid_i    <= w_valid_i_n;
      r_valid_j    <= w_valid_j_n;
      r_valid_r    <= w_valid_r_n;
      r_halted     <= r_halted | finish;
      r_packet_cnt <= w_packet_cnt_n;
      r_bubble_cnt <= w_bubble_cnt_n;
    end
  end

  assign pc_id       = r_pc;
  assign inst_i_id   = r_inst_i;
  assign inst_j_id   = r_inst_j;
  assign inst_r_id   = r_inst_r;
  assign valid_i_id  = r_valid_i;
  assign valid_j_id  = r_valid_j;
  assign valid_r_id  = r_valid_r;
  assign hazard      = w_hazard;
  assign halted      = r_halted;
  assign packet_cnt  = r_packet_cnt;
  assign bubble_cnt  = r_bubble_cnt;
  assign issue_count = {1'b0, r_valid_i} + {1'b0, r_valid_j} + {1'b0, r_valid_r};

endmodule

// File: tb/tb_if_id_register.sv
// Directed table-driven bench for if_id_register. A second instance with
// 2-bit counters shares the same stimulus to exercise counter saturation.
module tb_if_id_register;

  logic        clk;
  logic        btnc_i;
  logic [31:0] program_counter;
  logic [31:0] instruction_i, instruction_j, instruction_r;
  logic        type_i, type_j, type_r;
  logic        PCSrc, jump, finish, id_ex_memread;
  logic [4:0]  id_ex_rt;

  logic [31:0] pc_id, inst_i_id, inst_j_id, inst_r_id;
  logic        valid_i_id, valid_j_id, valid_r_id, hazard, halted;
  logic [15:0] packet_cnt, bubble_cnt;
  logic [1:0]  issue_count;

  logic [31:0] s_pc_id, s_inst_i_id, s_inst_j_id, s_inst_r_id;
  logic        s_valid_i_id, s_valid_j_id, s_valid_r_id, s_hazard, s_halted;
  logic [1:0]  s_packet_cnt, s_bubble_cnt, s_issue_count;

  int n_cmp  = 0;
  int n_miss = 0;

  if_id_register #(.CNT_W(16)) dut (
    .clk(clk), .btnc_i(btnc_i), .program_counter(program_counter),
    .instruction_i(instruction_i), .instruction_j(instruction_j),
    .instruction_r(instruction_r), .type_i(type_i), .type_j(type_j),
    .type_r(type_r), .PCSrc(PCSrc), .jump(jump), .finish(finish),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .pc_id(pc_id), .inst_i_id(inst_i_id), .inst_j_id(inst_j_id),
    .inst_r_id(inst_r_id), .valid_i_id(valid_i_id), .valid_j_id(valid_j_id),
    .valid_r_id(valid_r_id), .hazard(hazard), .halted(halted),
    .packet_cnt(packet_cnt), .bubble_cnt(bubble_cnt), .issue_count(issue_count)
  );

  if_id_register #(.CNT_W(2)) dut_sat (
    .clk(clk), .btnc_i(btnc_i), .program_counter(program_counter),
    .instruction_i(instruction_i), .instruction_j(instruction_j),
    .instruction_r(instruction_r), .type_i(type_i), .type_j(type_j),
    .type_r(type_r), .PCSrc(PCSrc), .jump(jump), .finish(finish),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .pc_id(s_pc_id), .inst_i_id(s_inst_i_id), .inst_j_id(s_inst_j_id),
    .inst_r_id(s_inst_r_id), .valid_i_id(s_valid_i_id), .valid_j_id(s_valid_j_id),
    .valid_r_id(s_valid_r_id), .hazard(s_hazard), .halted(s_halted),
    .packet_cnt(s_packet_cnt), .bubble_cnt(s_bubble_cnt), .issue_count(s_issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc, ii, ij, ir;
    logic [2:0]  t;      // {type_i, type_j, type_r}
    logic        pcs, jmp, fin, mr;
    logic [4:0]  rt;
    logic        chk_hz, hz;
    logic [31:0] e_pc, e_i, e_j, e_r;
    logic [2:0]  v;      // {valid_i, valid_j, valid_r}
    logic        hlt;
    int          pkt, bub;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic si(input int k, input logic rst, input logic [31:0] pc, ii, ij, ir,
                    input logic [2:0] t, input logic pcs, jmp, fin, mr,
                    input logic [4:0] rt);
    tv[k].rst = rst; tv[k].pc = pc; tv[k].ii = ii; tv[k].ij = ij; tv[k].ir = ir;
    tv[k].t = t; tv[k].pcs = pcs; tv[k].jmp = jmp; tv[k].fin = fin;
    tv[k].mr = mr; tv[k].rt = rt;
  endtask

  task automatic se(input int k, input logic chk_hz, hz, input logic [31:0] e_pc, e_i, e_j, e_r,
                    input logic [2:0] v, input logic hlt, input int pkt, bub);
    tv[k].chk_hz = chk_hz; tv[k].hz = hz; tv[k].e_pc = e_pc; tv[k].e_i = e_i;
    tv[k].e_j = e_j; tv[k].e_r = e_r; tv[k].v = v; tv[k].hlt = hlt;
    tv[k].pkt = pkt; tv[k].bub = bub;
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, k, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc, ii, ij, ir, input logic [2:0] t,
                       input logic pcs, jmp, fin, mr, input logic [4:0] rt);
    btnc_i = rst; program_counter = pc;
    instruction_i = ii; instruction_j = ij; instruction_r = ir;
    {type_i, type_j, type_r} = t;
    PCSrc = pcs; jump = jmp; finish = fin; id_ex_memread = mr; id_ex_rt = rt;
  endtask

  task automatic check_regs(input int k, input logic [31:0] e_pc, e_i, e_j, e_r,
                            input logic [2:0] v, input logic hlt, input int pkt, bub);
    chk("pc_id", k, pc_id, e_pc);
    chk("inst_i_id", k, inst_i_id, e_i);
    chk("inst_j_id", k, inst_j_id, e_j);
    chk("inst_r_id", k, inst_r_id, e_r);
    chk("valid", k, {29'd0, valid_i_id, valid_j_id, valid_r_id}, {29'd0, v});
    chk("issue_count", k, {30'd0, issue_count}, $countones(v));
    chk("halted", k, {31'd0, halted}, {31'd0, hlt});
    chk("packet_cnt", k, {16'd0, packet_cnt}, pkt);
    chk("bubble_cnt", k, {16'd0, bubble_cnt}, bub);
    chk("sat_packet_cnt", k, {30'd0, s_packet_cnt}, sat3(pkt));
    chk("sat_bubble_cnt", k, {30'd0, s_bubble_cnt}, sat3(bub));
  endtask

  task automatic apply(input int k);
    @(negedge clk);
    drive(tv[k].rst, tv[k].pc, tv[k].ii, tv[k].ij, tv[k].ir, tv[k].t,
          tv[k].pcs, tv[k].jmp, tv[k].fin, tv[k].mr, tv[k].rt);
    #1;
    if (tv[k].chk_hz) chk("hazard", k, {31'd0, hazard}, {31'd0, tv[k].hz});
    @(posedge clk);
    #1;
    check_regs(k, tv[k].e_pc, tv[k].e_i, tv[k].e_j, tv[k].e_r,
               tv[k].v, tv[k].hlt, tv[k].pkt, tv[k].bub);
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // reset
    si(0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0, 0, 5'd0);
    se(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0);
    // load R slot "add $10,$8,$9"
    si(1, 0, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 0, 0, 0, 5'd0);
    se(1, 1, 0, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 1, 0);
    // load-use on rs=8: hold, bubble per cycle
    si(2, 0, 32'hC, 32'h0, 32'h0, 32'h22222222, 3'b001, 0, 0, 0, 1, 5'd8);
    se(2, 1, 1, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 1, 1);
    si(3, 0, 32'hC, 32'h0, 32'h0, 32'h22222222, 3'b001, 0, 0, 0, 1, 5'd8);
    se(3, 1, 1, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 1, 2);
    // load-use on R rt field (9)
    si(4, 0, 32'hC, 32'h0, 32'h0, 32'h22222222, 3'b001, 0, 0, 0, 1, 5'd9);
    se(4, 1, 1, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 1, 3);
    // rt=0 never stalls; type_r=0 slot is stored as zero
    si(5, 0, 32'hC, 32'h8CA80000, 32'h08000010, 32'h12345678, 3'b110, 0, 0, 0, 1, 5'd0);
    se(5, 1, 0, 32'hC, 32'h8CA80000, 32'h08000010, 32'h0, 3'b110, 0, 2, 3);
    // held lw in I slot: its rt (8) is not a source -> no stall
    si(6, 0, 32'h10, 32'h20080005, 32'hFFFFFFFF, 32'h00A63020, 3'b101, 0, 0, 0, 1, 5'd8);
    se(6, 1, 0, 32'h10, 32'h20080005, 32'h0, 32'h00A63020, 3'b101, 0, 3, 3);
    // held addi in I slot: its rt (8) is a source -> stall
    si(7, 0, 32'h20, 32'h0, 32'h0, 32'h0, 3'b111, 0, 0, 0, 1, 5'd8);
    se(7, 1, 1, 32'h10, 32'h20080005, 32'h0, 32'h00A63020, 3'b101, 0, 3, 4);
    // flush coinciding with load-use match
    si(8, 0, 32'h40, 32'h11111111, 32'h22222222, 32'h33333333, 3'b111, 1, 0, 0, 1, 5'd8);
    se(8, 1, 0, 32'h40, 32'h0, 32'h0, 32'h0, 3'b000, 0, 3, 5);
    // jump flush
    si(9, 0, 32'h50, 32'h11111111, 32'h22222222, 32'h33333333, 3'b111, 0, 1, 0, 0, 5'd0);
    se(9, 1, 0, 32'h50, 32'h0, 32'h0, 32'h0, 3'b000, 0, 3, 6);
    // full packet
    si(10, 0, 32'h60, 32'h20080005, 32'h08000010, 32'h01095020, 3'b111, 0, 0, 0, 0, 5'd0);
    se(10, 1, 0, 32'h60, 32'h20080005, 32'h08000010, 32'h01095020, 3'b111, 0, 4, 6);
    // load in ID/EX with no matching source; empty packet does not count
    si(11, 0, 32'h70, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 3'b000, 0, 0, 0, 1, 5'd6);
    se(11, 1, 0, 32'h70, 32'h0, 32'h0, 32'h0, 3'b000, 0, 4, 6);
    si(12, 0, 32'h80, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 0, 0, 0, 5'd0);
    se(12, 1, 0, 32'h80, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 5, 6);
    // finish with an empty packet at the same PC
    si(13, 0, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 1, 0, 5'd0);
    se(13, 1, 0, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 1, 5, 6);
    // halted: flush/load-use/new packets all ignored, counters frozen
    si(14, 0, 32'h90, 32'h11111111, 32'h22222222, 32'h01095020, 3'b111, 1, 0, 0, 1, 5'd8);
    se(14, 1, 0, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 1, 5, 6);
    si(15, 0, 32'hA0, 32'h11111111, 32'h22222222, 32'h01095020, 3'b111, 0, 0, 0, 1, 5'd8);
    se(15, 1, 0, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 1, 5, 6);
    // reset out of halted
    si(16, 1, 32'hB0, 32'h11111111, 32'h22222222, 32'h01095020, 3'b111, 1, 0, 0, 1, 5'd8);
    se(16, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0);
    si(17, 0, 32'h4, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 0, 0, 0, 5'd0);
    se(17, 1, 0, 32'h4, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 1, 0);
    // reset overriding an active hazard hold
    si(18, 1, 32'h8, 32'h0, 32'h0, 32'h01095020, 3'b001, 0, 0, 0, 1, 5'd8);
    se(18, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 0);

    for (int k = 0; k < NV; k++) apply(k);

    // Long stall: bubble_cnt counts every cycle; the 2-bit copy saturates at 3.
    @(negedge clk);
    drive(1'b0, 32'h100, 32'h0, 32'h0, 32'h01095020, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    check_regs(100, 32'h100, 32'h0, 32'h0, 32'h01095020, 3'b001, 1'b0, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(1'b0, 32'h104, 32'h0, 32'h0, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
      #1;
      chk("stall_hazard", 100 + c, {31'd0, hazard}, 32'd1);
      @(posedge clk); #1;
      check_regs(100 + c, 32'h100, 32'h0, 32'h0, 32'h01095020, 3'b001, 1'b0, 1, c);
    end
    @(negedge clk);
    drive(1'b0, 32'h108, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
    #1;
    chk("release_hazard", 106, {31'd0, hazard}, 32'd0);
    @(posedge clk); #1;
    check_regs(106, 32'h108, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port btnc_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port program_counter  input  32  fetch-packet PC from IF.
REQ-005 SHALL have ports instruction_i, instruction_j, instruction_r  input  32 each  slot instructions from IF.
REQ-006 SHALL have ports type_i, type_j, type_r  input  1 each  slot-valid flags from IF.
REQ-007 SHALL have ports PCSrc, jump  input  1 each  branch-taken / jump redirect from later stages.
REQ-008 SHALL have port finish  input  1  program-end indication from IF.
REQ-009 SHALL have ports id_ex_memread  input  1 and id_ex_rt  input  5  load currently in ID/EX and its destination.
REQ-010 SHALL have ports pc_id  output  32, inst_i_id, inst_j_id, inst_r_id  output  32 each  registered packet.
REQ-011 SHALL have ports valid_i_id, valid_j_id, valid_r_id  output  1 each  registered slot-valid flags.
REQ-012 SHALL have port hazard  output  1  load-use stall request to IF (combinational).
REQ-013 SHALL have port halted  output  1  sticky end-of-program flag.
REQ-014 SHALL have ports packet_cnt, bubble_cnt  output  CNT_W each  performance counters.
REQ-015 SHALL have port issue_count  output  2  number of valid slots currently held (0-3).

Function
REQ-016 SHALL define flush = PCSrc | jump.
REQ-017 SHALL compute hazard = id_ex_memread & (id_ex_rt != 0) & !flush & !halted & match, where match is true for any valid held slot whose source equals id_ex_rt.
REQ-018 SHALL use as sources: R slot bits [25:21] and [20:16]; I slot bits [25:21], plus [20:16] unless opcode [31:26] = 6'b100011; J slot none.
REQ-019 SHALL apply update priority each cycle: reset > halted > flush > hazard > load.
REQ-020 SHALL on flush clear all valid flags and zero inst_*_id, and load pc_id from program_counter.
REQ-021 SHALL on hazard hold every registered output unchanged.
REQ-022 SHALL on load capture program_counter, instruction_*, type_* into the corresponding outputs (1-cycle latency); instruction with type=0 SHALL be stored as zero.
REQ-023 SHALL set halted on the first rising edge with finish=1; halted SHALL remain 1 until reset.
REQ-024 SHALL while halted load zeros into inst_*_id and valid_*_id, hold pc_id, and freeze both counters.
REQ-025 SHALL increment packet_cnt on each load in which at least one type_* is 1.
REQ-026 SHALL increment bubble_cnt on each non-halted cycle with flush or hazard.
REQ-027 SHALL saturate both counters at all-ones; no wrap-around.
REQ-028 SHALL derive issue_count combinationally as the sum of valid_i_id, valid_j_id, valid_r_id.
REQ-029 SHALL when flush and a load-use match coincide, perform the flush and hold hazard at 0.

Reset
REQ-030 SHALL on btnc_i=1 at a rising edge drive all registered outputs, halted and counters to 0; hazard SHALL then evaluate to 0.
REQ-031 SHALL let reset override an in-progress hazard hold or halted state in the same cycle.

Verification
REQ-032 Load: PC=0x8, inst_r=0x01095020, type_r=1 -> next cycle pc_id=0x8, valid_r_id=1, issue_count=1, packet_cnt=1.
REQ-033 Load-use: held R slot rs=8, id_ex_memread=1, id_ex_rt=8 -> hazard=1, outputs held, bubble_cnt increments per cycle.
REQ-034 rt=0: same as REQ-033 but id_ex_rt=0 -> hazard=0, normal load.
REQ-035 Flush+hazard: PCSrc=1 with active load-use match -> hazard=0, all valid flags 0 next cycle, bubble_cnt +1.
REQ-036 Halt: finish=1 one cycle -> halted=1 thereafter, valid flags 0, counters frozen; btnc_i=1 -> all outputs 0.
REQ-037 Saturation: CNT_W=2, 5 valid loads -> packet_cnt=3 and stays 3.
